// File: rtl/demux_1to2_buffered_if.sv
// Handshake bundle for the buffered 1-to-2 demux: one upstream producer port and two
// downstream consumer ports, each consumer fed by its own 2-entry queue.
interface demux_1to2_buffered_if #(
    parameter int unsigned WIDTH = 32
);
    // Upstream side
    logic [WIDTH-1:0] inData;
    logic             inValid;
    logic             sel;
    logic             inReady;

    // Consumer A
    logic [WIDTH-1:0] outA;
    logic             outAValid;
    logic             outAReady;

    // Consumer B
    logic [WIDTH-1:0] outB;
    logic             outBValid;
    logic             outBReady;

    // Queue occupancy (0..2)
    logic [1:0]       levelA;
    logic [1:0]       levelB;

    // Environment view: drives the offered word and the consumer pop requests
    modport master (
        output inData,
        output inValid,
        output sel,
        input  inReady,
        input  outA,
        input  outAValid,
        output outAReady,
        input  outB,
        input  outBValid,
        output outBReady,
        input  levelA,
        input  levelB
    );

    // Block view
    modport slave (
        input  inData,
        input  inValid,
        input  sel,
        output inReady,
        output outA,
        output outAValid,
        input  outAReady,
        output outB,
        output outBValid,
        input  outBReady,
        output levelA,
        output levelB
    );
endinterface

// File: rtl/demux_1to2_buffered.sv
// Buffered 1-to-2 demux. Each accepted word is routed by sel into one of two independent
// 2-entry FIFOs (index 0 = queue A, index 1 = queue B). Each queue's head word is held in
// a dedicated register so outA/outB never see a combinational path from inData.
module demux_1to2_buffered #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   Clk,
    input  logic                   Rst,
    demux_1to2_buffered_if.slave   bus
);

    // Registered queue state
    logic [WIDTH-1:0] r_mem   [2][2];
    logic [1:0]       r_level [2];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [WIDTH-1:0] r_head  [2];

    // Next-state and handshake wires
    logic             w_in_ready;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_level_d [2];
    logic [1:0]       w_wr_ptr_d;
    logic [1:0]       w_rd_ptr_d;
    logic [WIDTH-1:0] w_head_d  [2];
    logic [1:0]       w_head_load;

    // Ready depends only on sel and registered levels, so a full queue refuses a push
    // even when it is being popped in the same cycle.
    assign w_in_ready = bus.sel ? (r_level[1] != 2'd2) : (r_level[0] != 2'd2);

    // Push goes to exactly one queue, chosen by sel on the accepting cycle
    assign w_push[0] = bus.inValid && w_in_ready && !bus.sel;
    assign w_push[1] = bus.inValid && w_in_ready &&  bus.sel;

    // Pop only when the queue holds something; ready on an empty queue is ignored
    assign w_pop[0] = (r_level[0] != 2'd0) && bus.outAReady;
    assign w_pop[1] = (r_level[1] != 2'd0) && bus.outBReady;

    // Next level, pointers and head word for each queue
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            w_level_d[q] = r_level[q];
            unique case ({w_push[q], w_pop[q]})
                2'b10:   w_level_d[q] = r_level[q] + 2'd1;
                2'b01:   w_level_d[q] = r_level[q] - 2'd1;
                default: w_level_d[q] = r_level[q];
            endcase

            w_wr_ptr_d[q] = r_wr_ptr[q] ^ w_push[q];
            w_rd_ptr_d[q] = r_rd_ptr[q] ^ w_pop[q];

            // If this cycle's write lands in the slot that becomes the head, forward it;
            // this covers a push into an empty queue and push+pop at level 1.
            if (w_push[q] && (r_wr_ptr[q] == w_rd_ptr_d[q])) begin
                w_head_d[q] = bus.inData;
            end else begin
                w_head_d[q] = r_mem[q][w_rd_ptr_d[q]];
            end

            // An emptied queue keeps presenting its last word
            w_head_load[q] = (w_level_d[q] != 2'd0);
        end
    end

    // Levels and pointers; pointers are single bits that wrap naturally
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int q = 0; q < 2; q++) begin
                r_level[q] <= 2'd0;
            end
            r_wr_ptr <= 2'b00;
            r_rd_ptr <= 2'b00;
        end else begin
            for (int q = 0; q < 2; q++) begin
                r_level[q] <= w_level_d[q];
            end
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
        end
    end

    // Storage: write the accepted word at the routed queue's write pointer
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int q = 0; q < 2; q++) begin
                for (int e = 0; e < 2; e++) begin
                    r_mem[q][e] <= '0;
                end
            end
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (w_push[q]) begin
                    r_mem[q][r_wr_ptr[q]] <= bus.inData;
                end
            end
        end
    end

    // Registered head words that drive outA/outB
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int q = 0; q < 2; q++) begin
                r_head[q] <= '0;
            end
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (w_head_load[q]) begin
                    r_head[q] <= w_head_d[q];
                end
            end
        end
    end

    assign bus.inReady   = w_in_ready;
    assign bus.outA      = r_head[0];
    assign bus.outAValid = (r_level[0] != 2'd0);
    assign bus.levelA    = r_level[0];
    assign bus.outB      = r_head[1];
    assign bus.outBValid = (r_level[1] != 2'd0);
    assign bus.levelB    = r_level[1];

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed bench for demux_1to2_buffered: reset, routing, full stall, full-with-pop,
// streaming with pointer wrap, and mid-operation reset.
module tb_demux_1to2_buffered;

    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_err;

    demux_1to2_buffered_if #(.WIDTH(32)) bus ();

    demux_1to2_buffered #(.WIDTH(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset held with stale traffic on the inputs, checked before any edge
        Rst           = 1'b0;
        bus.inValid   = 1'b1;
        bus.sel       = 1'b0;
        bus.inData    = 32'hDEADBEEF;
        bus.outAReady = 1'b1;
        bus.outBReady = 1'b1;
        #3;
        chk("rst_outAValid", {31'd0, bus.outAValid}, 32'd0);
        chk("rst_outBValid", {31'd0, bus.outBValid}, 32'd0);
        chk("rst_levelA", {30'd0, bus.levelA}, 32'd0);
        chk("rst_levelB", {30'd0, bus.levelB}, 32'd0);
        chk("rst_outA", bus.outA, 32'd0);
        chk("rst_outB", bus.outB, 32'd0);
        tick();
        tick();
        chk("rst_hold_levelA", {30'd0, bus.levelA}, 32'd0);
        chk("rst_hold_outA", bus.outA, 32'd0);

        bus.inValid   = 1'b0;
        bus.outAReady = 1'b0;
        bus.outBReady = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;

        // Routing: first edge after release accepts the push
        bus.inValid = 1'b1;
        bus.sel     = 1'b0;
        bus.inData  = 32'h11111111;
        tick();
        chk("route_levelA", {30'd0, bus.levelA}, 32'd1);
        chk("route_outA", bus.outA, 32'h11111111);
        chk("route_outAValid", {31'd0, bus.outAValid}, 32'd1);
        chk("route_levelB_idle", {30'd0, bus.levelB}, 32'd0);
        bus.sel    = 1'b1;
        bus.inData = 32'h22222222;
        tick();
        chk("route_levelB", {30'd0, bus.levelB}, 32'd1);
        chk("route_outB", bus.outB, 32'h22222222);
        chk("route_levelA_kept", {30'd0, bus.levelA}, 32'd1);
        chk("route_outA_kept", bus.outA, 32'h11111111);

        // Drain both; outA/outB keep their last value once empty
        bus.inValid   = 1'b0;
        bus.outAReady = 1'b1;
        bus.outBReady = 1'b1;
        tick();
        chk("drain_levelA", {30'd0, bus.levelA}, 32'd0);
        chk("drain_outBValid", {31'd0, bus.outBValid}, 32'd0);
        chk("drain_outA_hold", bus.outA, 32'h11111111);
        chk("drain_outB_hold", bus.outB, 32'h22222222);
        bus.outAReady = 1'b0;
        bus.outBReady = 1'b0;
        tick();
        chk("empty_ready_noeffect", {30'd0, bus.levelA}, 32'd0);

        // Full stall on queue A
        bus.inValid = 1'b1;
        bus.sel     = 1'b0;
        bus.inData  = 32'hA0;
        tick();
        chk("fill1_levelA", {30'd0, bus.levelA}, 32'd1);
        bus.inData = 32'hA1;
        tick();
        chk("fill2_levelA", {30'd0, bus.levelA}, 32'd2);
        chk("full_inReady_sel0", {31'd0, bus.inReady}, 32'd0);
        chk("full_outA_head", bus.outA, 32'hA0);
        bus.inData = 32'hA2;
        tick();
        chk("stall_levelA", {30'd0, bus.levelA}, 32'd2);
        chk("stall_outA", bus.outA, 32'hA0);
        bus.sel = 1'b1;
        #1;
        chk("full_inReady_sel1", {31'd0, bus.inReady}, 32'd1);
        bus.sel = 1'b0;
        #1;
        chk("full_inReady_back", {31'd0, bus.inReady}, 32'd0);

        // Full with pop: A0 leaves, A2 refused this cycle, accepted the next
        bus.outAReady = 1'b1;
        tick();
        chk("fullpop_levelA", {30'd0, bus.levelA}, 32'd1);
        chk("fullpop_outA", bus.outA, 32'hA1);
        chk("fullpop_inReady", {31'd0, bus.inReady}, 32'd1);
        bus.outAReady = 1'b0;
        tick();
        chk("accept_levelA", {30'd0, bus.levelA}, 32'd2);
        chk("accept_outA", bus.outA, 32'hA1);
        bus.inValid   = 1'b0;
        bus.outAReady = 1'b1;
        tick();
        chk("drainA_outA", bus.outA, 32'hA2);
        chk("drainA_level1", {30'd0, bus.levelA}, 32'd1);
        tick();
        chk("drainA_level0", {30'd0, bus.levelA}, 32'd0);
        chk("isolate_levelB", {30'd0, bus.levelB}, 32'd0);
        chk("isolate_outB", bus.outB, 32'h22222222);

        // Streaming 0..7 through queue A with continuous pop
        bus.inValid = 1'b1;
        bus.sel     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.inData = i;
            tick();
            chk($sformatf("stream_outA_%0d", i), bus.outA, i);
            chk($sformatf("stream_level_%0d", i), {30'd0, bus.levelA}, 32'd1);
        end
        bus.inValid = 1'b0;
        tick();
        chk("stream_end_level", {30'd0, bus.levelA}, 32'd0);
        chk("stream_end_outA", bus.outA, 32'd7);

        // Mid-operation reset with levelA=2, levelB=1
        bus.outAReady = 1'b0;
        bus.outBReady = 1'b0;
        bus.inValid   = 1'b1;
        bus.sel       = 1'b0;
        bus.inData    = 32'hC0;
        tick();
        bus.inData = 32'hC1;
        tick();
        bus.sel    = 1'b1;
        bus.inData = 32'hB0;
        tick();
        chk("pre_rst_levelA", {30'd0, bus.levelA}, 32'd2);
        chk("pre_rst_levelB", {30'd0, bus.levelB}, 32'd1);
        bus.inValid = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        chk("midrst_levelA", {30'd0, bus.levelA}, 32'd0);
        chk("midrst_levelB", {30'd0, bus.levelB}, 32'd0);
        chk("midrst_outAValid", {31'd0, bus.outAValid}, 32'd0);
        chk("midrst_outBValid", {31'd0, bus.outBValid}, 32'd0);
        chk("midrst_outA", bus.outA, 32'd0);
        chk("midrst_outB", bus.outB, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        bus.inValid = 1'b1;
        bus.sel     = 1'b1;
        bus.inData  = 32'h5;
        tick();
        chk("post_rst_outB", bus.outB, 32'h5);
        chk("post_rst_levelB", {30'd0, bus.levelB}, 32'd1);
        chk("post_rst_levelA", {30'd0, bus.levelA}, 32'd0);
        chk("post_rst_outA", bus.outA, 32'd0);
        bus.inValid = 1'b0;
        tick();
        chk("post_rst_no_stale", {30'd0, bus.levelB}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
